// File: rtl/store_merge.sv
// Store-side data narrowing with read-modify-write merge into a word-only RAM.
// Sub-word stores read the target word, splice in the new lanes and write it back.
module store_merge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  done,
  output logic                  misalign
);

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StErr} state_e;

  state_e      state_q;
  logic [1:0]  lane_q;
  logic        half_q;
  logic [15:0] data_q;

  logic                  accept;
  logic                  word_ok;
  logic                  sub_ok;
  logic [3:0]            lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] merged;

  assign accept  = req_valid && req_ready;
  assign word_ok = (req_size == 2'b10) && (req_addr[1:0] == 2'b00);
  assign sub_ok  = (req_size == 2'b00) || ((req_size == 2'b01) && !req_addr[0]);

  // Replicate the store data across lanes, then pick new or old byte per lane.
  always_comb begin
    lane_data = '0;
    lane_mask = 4'b0000;
    if (half_q) begin
      lane_data = {2{data_q[15:0]}};
      lane_mask = lane_q[1] ? 4'b1100 : 4'b0011;
    end else begin
      lane_data = {4{data_q[7:0]}};
      lane_mask = 4'b0001 << lane_q;
    end
    merged = '0;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = lane_mask[k] ? lane_data[8*k +: 8] : mem_rdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lane_q    <= 2'b00;
      half_q    <= 1'b0;
      data_q    <= '0;
      req_ready <= 1'b1;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      done      <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            lane_q    <= req_addr[1:0];
            half_q    <= req_size[0];
            data_q    <= req_data[15:0];
            req_ready <= 1'b0;
            if (word_ok) begin
              // Full words need no read; write straight through.
              state_q   <= StWrite;
              mem_addr  <= req_addr[ADDR_WIDTH-1:2];
              mem_we    <= 1'b1;
              mem_wdata <= req_data;
              done      <= 1'b1;
            end else if (sub_ok) begin
              state_q  <= StRead;
              mem_addr <= req_addr[ADDR_WIDTH-1:2];
              mem_re   <= 1'b1;
            end else begin
              state_q  <= StErr;
              misalign <= 1'b1;
            end
          end
        end
        StRead: begin
          state_q <= StMerge;
        end
        StMerge: begin
          state_q   <= StWrite;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
          done      <= 1'b1;
        end
        StWrite, StErr: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: a word RAM model plus a timed event scoreboard.
module tb_store_merge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_data = '0;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        misalign;

  store_merge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_data  (req_data),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .done      (done),
    .misalign  (misalign)
  );

  initial forever #5 clk = ~clk;

  // Kinds: 0 read, 1 write, 2 misalign.
  typedef struct {
    int          kind;
    logic [29:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [256];
  int          cyc = 0;
  int          busy_s = 0;
  int          busy_e = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take(input int kind, input logic [29:0] a, input logic [31:0] d);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: kind %0d addr 0x%08h data 0x%08h, none expected (cycle %0d)",
               kind, {2'b00, a}, d, cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      if (kind != 2) chk("event_addr", {2'b00, a}, {2'b00, e.addr});
      if (kind == 1) chk("write_data", d, e.data);
    end
  endtask

  // Monitor: every DUT strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !(cyc >= busy_s && cyc < busy_e)});
      chk("re_we_excl", {31'b0, mem_re & mem_we}, 32'd0);
      chk("done_with_we", {31'b0, done}, {31'b0, mem_we});
      chk("done_mis_excl", {31'b0, done & misalign}, 32'd0);
      if (mem_re) take(0, mem_addr, 32'h0);
      if (mem_we) take(1, mem_addr, mem_wdata);
      if (misalign) take(2, 30'h0, 32'h0);
    end
  end

  // cls: 0 sub-word, 1 word, 2 reject, 3 sub-word aborted by reset (read only).
  task automatic send(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                      input int cls, input logic [31:0] expw, output int t);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_size  = size;
    req_data  = data;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready stuck 0, expected 1 within 20 cycles");
    end
    t = cyc + 1;
    busy_s = t;
    busy_e = t + ((cls == 0 || cls == 3) ? 3 : 1);
    e.addr = addr[31:2];
    e.data = expw;
    if (cls == 0 || cls == 3) begin
      e.kind = 0; e.cyc = t; sb.push_back(e);
    end
    if (cls == 0) begin
      e.kind = 1; e.cyc = t + 2; sb.push_back(e);
    end
    if (cls == 1) begin
      e.kind = 1; e.cyc = t; sb.push_back(e);
    end
    if (cls == 2) begin
      e.kind = 2; e.cyc = t; sb.push_back(e);
    end
  endtask

  // Drop valid after acceptance and scramble inputs; they must be ignored.
  task automatic release_req(input int gap);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_size  = 2'b10;
    req_data  = 32'h5A5A_5A5A;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_re", {31'b0, mem_re}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    int t1, t2;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    #23;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Byte store into lane 2.
    mem[8'h40] = 32'h1122_3344;
    send(32'h102, 2'b00, 32'hFFFF_FFAB, 0, 32'h11AB_3344, t1);
    release_req(5);

    // Upper half, then a byte into lane 3 on top of it.
    mem[8'h40] = 32'h1122_3344;
    send(32'h102, 2'b01, 32'h1234_BEEF, 0, 32'hBEEF_3344, t1);
    release_req(5);
    send(32'h103, 2'b00, 32'h0000_0077, 0, 32'h77EF_3344, t1);
    release_req(5);

    // Aligned word: no read, write one cycle after acceptance.
    send(32'h100, 2'b10, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, t1);
    release_req(3);

    // Rejected requests.
    send(32'h101, 2'b01, 32'h1111_1111, 2, 32'h0, t1);
    release_req(3);
    send(32'h102, 2'b10, 32'h2222_2222, 2, 32'h0, t1);
    release_req(3);
    send(32'h100, 2'b11, 32'h3333_3333, 2, 32'h0, t1);
    release_req(3);

    // Valid held high across two byte stores.
    mem[8'h40] = 32'h0;
    send(32'h100, 2'b00, 32'h0000_0001, 0, 32'h0000_0001, t1);
    send(32'h101, 2'b00, 32'h0000_0002, 0, 32'h0000_0201, t2);
    chk("b2b_accept_gap", 32'(t2 - t1), 32'd4);
    release_req(5);

    // Reset during MERGE of a byte store: no write, memory untouched.
    mem[8'h40] = 32'h1122_3344;
    send(32'h100, 2'b00, 32'h0000_0055, 3, 32'h0, t1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b0;
    busy_s = 0;
    busy_e = 0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mem_after_reset", mem[8'h40], 32'h1122_3344);
    send(32'h101, 2'b00, 32'h0000_009A, 0, 32'h1122_9A44, t1);
    release_req(5);
    chk("mem_final", mem[8'h40], 32'h1122_9A44);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
